// File: rtl/ahb_memory_slave_pkg.sv
// Shared AHB-Lite widths, transfer/response encodings, slave FSM states and pending-phase payload.
// AHB_MEM_WAIT_STATES_EN adds the WAIT_ST state used by the optional wait-state build.
package definesPkg;

   localparam int unsigned ADDRESS_WIDTH  = 32;
   localparam int unsigned DATA_WIDTH     = 32;
   localparam int unsigned HSIZE_WIDTH    = 3;
   localparam int unsigned BURST_WIDTH    = 3;
   localparam int unsigned TRANSFER_WIDTH = 2;

   localparam logic [TRANSFER_WIDTH-1:0] IDLE    = 2'b00;
   localparam logic [TRANSFER_WIDTH-1:0] BUSY    = 2'b01;
   localparam logic [TRANSFER_WIDTH-1:0] NON_SEQ = 2'b10;
   localparam logic [TRANSFER_WIDTH-1:0] SEQ     = 2'b11;

   localparam logic [HSIZE_WIDTH-1:0] HSIZE_WORD = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ADDR_ST,
      DATA_ST,
      ERR1_ST,
      ERR2_ST
`ifdef AHB_MEM_WAIT_STATES_EN
      , WAIT_ST
`endif
   } state_e;

   typedef struct packed {
      logic [ADDRESS_WIDTH-1:0] addr;
      logic                     write;
   } pend_t;

   function automatic logic is_active(input logic [TRANSFER_WIDTH-1:0] trans);
      return (trans == NON_SEQ) || (trans == SEQ);
   endfunction

endpackage

// File: rtl/ahb_memory_slave_array.sv
// Word storage for the AHB slave: RW array above the ROM region, one write port,
// one registered read port with ROM pattern and same-edge write forwarding.
module ahb_mem_array
   import definesPkg::*;
#(
   parameter int unsigned MEM_DEPTH = 256,
   parameter int unsigned RO_DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we_i,
   input  logic [ADDRESS_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0]    wr_data_i,
   input  logic                     rd_en_i,
   input  logic                     rd_clr_i,
   input  logic [ADDRESS_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0]    rd_data_o
);

   localparam int unsigned RW_DEPTH = MEM_DEPTH - RO_DEPTH;
   localparam int unsigned IDX_W    = $clog2(RW_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [RW_DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic [IDX_W-1:0]      wr_idx_c, rd_idx_c;
   logic [DATA_WIDTH-1:0] rd_word_c;

   assign wr_idx_c = IDX_W'(wr_addr_i - ADDRESS_WIDTH'(RO_DEPTH));
   assign rd_idx_c = IDX_W'(rd_addr_i - ADDRESS_WIDTH'(RO_DEPTH));

   // ROM pattern, then a write committing on this edge, then stored word.
   always_comb begin
      rd_word_c = mem_q[rd_idx_c];
      if (rd_addr_i < ADDRESS_WIDTH'(RO_DEPTH)) begin
         rd_word_c = DATA_WIDTH'(rd_addr_i);
      end else if (we_i && (wr_addr_i == rd_addr_i)) begin
         rd_word_c = wr_data_i;
      end
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_clr_i) begin
         rd_data_d = '0;
      end else if (rd_en_i) begin
         rd_data_d = rd_word_c;
      end
   end

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[wr_idx_c] <= wr_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ahb_memory_slave.sv
// AHB-Lite single-slave memory responder with two-cycle ERROR responses.
// Define AHB_MEM_WAIT_STATES_EN to insert WAIT_STATES cycles before each legal data phase.
module ahb_memory_slave
   import definesPkg::*;
#(
   parameter int unsigned MEM_DEPTH   = 256,
   parameter int unsigned RO_DEPTH    = 16,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic [ADDRESS_WIDTH-1:0]  HADDR,
   input  logic                      HWRITE,
   input  logic [HSIZE_WIDTH-1:0]    HSIZE,
   input  logic [BURST_WIDTH-1:0]    HBURST,
   input  logic [TRANSFER_WIDTH-1:0] HTRANS,
   input  logic [DATA_WIDTH-1:0]     HWDATA,
   output logic [DATA_WIDTH-1:0]     HRDATA,
   output logic                      HREADY,
   output logic                      HRESP
);

   state_e                   state_q, state_d;
   pend_t                    pend_q, pend_d;
   logic                     hready_q, hready_d;
   logic                     hresp_q, hresp_d;
   logic                     accept_c, illegal_c;
   logic                     we_c, rd_en_c, rd_clr_c;
   logic [ADDRESS_WIDTH-1:0] rd_addr_c;
   logic                     unused_burst_c;

`ifdef AHB_MEM_WAIT_STATES_EN
   localparam int unsigned WAIT_CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
   logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`else
   localparam int unsigned unused_wait_states = WAIT_STATES;
`endif

   assign unused_burst_c = ^HBURST;

   assign accept_c  = hready_q && is_active(HTRANS);
   assign illegal_c = (HADDR >= ADDRESS_WIDTH'(MEM_DEPTH))
                   || (HWRITE && (HADDR < ADDRESS_WIDTH'(RO_DEPTH)))
                   || (HSIZE != HSIZE_WORD);

   // Next state, pending phase, array controls and next response outputs.
   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      we_c      = 1'b0;
      rd_en_c   = 1'b0;
      rd_addr_c = HADDR;
`ifdef AHB_MEM_WAIT_STATES_EN
      wait_cnt_d = '0;
`endif
      case (state_q)
         ADDR_ST, DATA_ST, ERR2_ST: begin
            we_c = (state_q == DATA_ST) && pend_q.write;
            if (accept_c) begin
               pend_d = '{addr: HADDR, write: HWRITE};
               if (illegal_c) begin
                  state_d = ERR1_ST;
               end else begin
`ifdef AHB_MEM_WAIT_STATES_EN
                  state_d = WAIT_ST;
`else
                  state_d = DATA_ST;
                  rd_en_c = !HWRITE;
`endif
               end
            end else begin
               state_d = ADDR_ST;
            end
         end
         ERR1_ST: state_d = ERR2_ST;
`ifdef AHB_MEM_WAIT_STATES_EN
         WAIT_ST: begin
            if (wait_cnt_q == WAIT_CNT_W'(WAIT_STATES - 1)) begin
               state_d   = DATA_ST;
               rd_en_c   = !pend_q.write;
               rd_addr_c = pend_q.addr;
            end else begin
               wait_cnt_d = WAIT_CNT_W'(wait_cnt_q + 1'b1);
            end
         end
`endif
         default: state_d = ADDR_ST;
      endcase

      hready_d = (state_d != ERR1_ST);
`ifdef AHB_MEM_WAIT_STATES_EN
      if (state_d == WAIT_ST) hready_d = 1'b0;
`endif
      hresp_d  = ((state_d == ERR1_ST) || (state_d == ERR2_ST)) ? HRESP_ERROR : HRESP_OKAY;
      rd_clr_c = (state_d == ERR1_ST);
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= ADDR_ST;
         pend_q   <= '0;
         hready_q <= 1'b1;
         hresp_q  <= HRESP_OKAY;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         hready_q <= hready_d;
         hresp_q  <= hresp_d;
      end
   end

`ifdef AHB_MEM_WAIT_STATES_EN
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end
`endif

   ahb_mem_array #(
      .MEM_DEPTH (MEM_DEPTH),
      .RO_DEPTH  (RO_DEPTH)
   ) u_array (
      .clk       (HCLK),
      .rst_n     (HRESETn),
      .we_i      (we_c),
      .wr_addr_i (pend_q.addr),
      .wr_data_i (HWDATA),
      .rd_en_i   (rd_en_c),
      .rd_clr_i  (rd_clr_c),
      .rd_addr_i (rd_addr_c),
      .rd_data_o (HRDATA)
   );

   assign HREADY = hready_q;
   assign HRESP  = hresp_q;

endmodule

// File: tb/tb_ahb_memory_slave.sv
// Directed self-checking bench for ahb_memory_slave (zero-wait build, or
// AHB_MEM_WAIT_STATES_EN with WAIT_STATES = 2).
module tb_ahb_memory_slave;
   import definesPkg::*;

`ifdef AHB_MEM_WAIT_STATES_EN
   localparam int WS = 2;
`else
   localparam int WS = 0;
`endif
   localparam int unsigned DUT_WS = (WS == 0) ? 1 : WS;

   logic                      HCLK;
   logic                      HRESETn;
   logic [ADDRESS_WIDTH-1:0]  HADDR;
   logic                      HWRITE;
   logic [HSIZE_WIDTH-1:0]    HSIZE;
   logic [BURST_WIDTH-1:0]    HBURST;
   logic [TRANSFER_WIDTH-1:0] HTRANS;
   logic [DATA_WIDTH-1:0]     HWDATA;
   logic [DATA_WIDTH-1:0]     HRDATA;
   logic                      HREADY;
   logic                      HRESP;

   int n_checks = 0;
   int n_fail   = 0;

   ahb_memory_slave #(
      .MEM_DEPTH   (256),
      .RO_DEPTH    (16),
      .WAIT_STATES (DUT_WS)
   ) dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .HADDR   (HADDR),
      .HWRITE  (HWRITE),
      .HSIZE   (HSIZE),
      .HBURST  (HBURST),
      .HTRANS  (HTRANS),
      .HWDATA  (HWDATA),
      .HRDATA  (HRDATA),
      .HREADY  (HREADY),
      .HRESP   (HRESP)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic addr_ph(input logic [1:0] t, input logic [31:0] a, input logic w);
      HTRANS = t;
      HADDR  = a;
      HWRITE = w;
   endtask

   task automatic wait_ready(output int low);
      low = 0;
      while ((HREADY !== 1'b1) && (low < 16)) begin
         tick();
         low++;
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      int low;
      addr_ph(NON_SEQ, a, 1'b1);
      tick();
      HTRANS = IDLE;
      HWDATA = d;
      wait_ready(low);
      chk("wr_wait_cycles", 32'(low), 32'(WS));
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      int low;
      addr_ph(NON_SEQ, a, 1'b0);
      tick();
      HTRANS = IDLE;
      wait_ready(low);
      chk("rd_wait_cycles", 32'(low), 32'(WS));
      chk("rd_hresp", 32'(HRESP), 32'(HRESP_OKAY));
      d = HRDATA;
   endtask

   task automatic err(input string tag, input logic [31:0] a, input logic w, input logic [2:0] sz);
      addr_ph(NON_SEQ, a, w);
      HSIZE  = sz;
      HWDATA = 32'h0000_0001;
      tick();
      HTRANS = IDLE;
      HSIZE  = HSIZE_WORD;
      chk({tag, "_e1_hready"}, 32'(HREADY), 32'd0);
      chk({tag, "_e1_hresp"},  32'(HRESP),  32'd1);
      chk({tag, "_e1_hrdata"}, HRDATA,      32'd0);
      tick();
      chk({tag, "_e2_hready"}, 32'(HREADY), 32'd1);
      chk({tag, "_e2_hresp"},  32'(HRESP),  32'd1);
      tick();
      chk({tag, "_after_hresp"}, 32'(HRESP), 32'd0);
   endtask

   initial begin
      logic [31:0] d;
      int low;
      HRESETn = 1'b0;
      HADDR   = '0;
      HWRITE  = 1'b0;
      HSIZE   = HSIZE_WORD;
      HBURST  = '0;
      HTRANS  = IDLE;
      HWDATA  = '0;
      repeat (3) tick();
      HRESETn = 1'b1;
      tick();
      chk("reset_hready", 32'(HREADY), 32'd1);
      chk("reset_hresp",  32'(HRESP),  32'd0);
      chk("reset_hrdata", HRDATA,      32'd0);

      // Reset during the data phase of a write aborts it.
      addr_ph(NON_SEQ, 32'h20, 1'b1);
      tick();
      HTRANS = IDLE;
      HWDATA = 32'h1234_5678;
      wait_ready(low);
      HRESETn = 1'b0;
      #1;
      chk("midrst_hready", 32'(HREADY), 32'd1);
      chk("midrst_hresp",  32'(HRESP),  32'd0);
      chk("midrst_hrdata", HRDATA,      32'd0);
      tick();
      HRESETn = 1'b1;
      tick();
      rd(32'h20, d);
      n_checks++;
      assert (d !== 32'h1234_5678) else begin
         n_fail++;
         $error("FAIL aborted_write_committed observed=0x%h expected=not 0x12345678", d);
      end

      // Single write then read.
      wr(32'h20, 32'hDEAD_BEEF);
      tick();
      rd(32'h20, d);
      chk("single_rd", d, 32'hDEAD_BEEF);

      // ROM region.
      rd(32'h05, d);
      chk("rom_rd_5", d, 32'h5);
      err("rom_wr_5", 32'h05, 1'b1, HSIZE_WORD);
      rd(32'h05, d);
      chk("rom_reread_5", d, 32'h5);
      rd(32'h0F, d);
      chk("rom_rd_f", d, 32'hF);
      rd(32'h00, d);
      chk("rom_rd_0", d, 32'h0);
      err("rom_wr_f", 32'h0F, 1'b1, HSIZE_WORD);

      // Illegal address and size.
      err("rd_oob_100", 32'h100, 1'b0, HSIZE_WORD);
      err("rd_oob_wide", 32'h0001_0020, 1'b0, HSIZE_WORD);
      err("rd_half", 32'h40, 1'b0, 3'b001);

      // INCR4 write with one BUSY after beat 2, then INCR4 read.
      HBURST = 3'b011;
      addr_ph(NON_SEQ, 32'h40, 1'b1);
      tick();
      addr_ph(SEQ, 32'h41, 1'b1);
      HWDATA = 32'd1;
      wait_ready(low);
      chk("bw1_wait", 32'(low), 32'(WS));
      tick();
      addr_ph(BUSY, 32'h42, 1'b1);
      HWDATA = 32'd2;
      wait_ready(low);
      chk("bw2_wait", 32'(low), 32'(WS));
      tick();
      chk("busy_hready", 32'(HREADY), 32'd1);
      chk("busy_hresp",  32'(HRESP),  32'd0);
      addr_ph(SEQ, 32'h42, 1'b1);
      tick();
      addr_ph(SEQ, 32'h43, 1'b1);
      HWDATA = 32'd3;
      wait_ready(low);
      chk("bw3_wait", 32'(low), 32'(WS));
      tick();
      HTRANS = IDLE;
      HWDATA = 32'd4;
      wait_ready(low);
      chk("bw4_wait", 32'(low), 32'(WS));
      tick();

      addr_ph(NON_SEQ, 32'h40, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i < 3) addr_ph(SEQ, 32'h41 + 32'(i), 1'b0);
         else       HTRANS = IDLE;
         wait_ready(low);
         chk($sformatf("br%0d_wait", i), 32'(low), 32'(WS));
         chk($sformatf("br%0d_data", i), HRDATA, 32'(i + 1));
         chk($sformatf("br%0d_hresp", i), 32'(HRESP), 32'd0);
         tick();
      end
      HBURST = '0;

      // Write immediately followed by read of the same word.
      wr(32'h30, 32'hA5A5_A5A5);
      rd(32'h30, d);
      chk("hazard_rd", d, 32'hA5A5_A5A5);

      // First RW word and last legal word.
      wr(32'h10, 32'h1111_1111);
      wr(32'hFF, 32'hFFFF_0000);
      tick();
      rd(32'h10, d);
      chk("rd_first_rw", d, 32'h1111_1111);
      rd(32'hFF, d);
      chk("rd_last", d, 32'hFFFF_0000);
      rd(32'h30, d);
      chk("rd_30_again", d, 32'hA5A5_A5A5);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
